polyeval_mac_pipe: RTL and testbench
====================================

# polyeval_mac_pipe

Pipelined modular multiply-accumulate step for the polynomial evaluator. It computes `(a_left ± a_right·factor) mod MOD_NUM` and carries the evaluation order count alongside each result. This is the parametrised successor of the single-cycle evaluator ALU: it adds a two-stage pipeline, valid/ready backpressure, an add/subtract mode, and order-count wrap and last-term flags. It sits between the coefficient/operand fetch logic and the result writeback of the evaluator.

## Interface
Parameters:
- `WID_D`, 32: operand and result width.
- `WID_F`, 32: factor width.
- `CNT_W`, 5: order counter width.
- `MOD_NUM`, 30: modulus. Must satisfy 2 ≤ MOD_NUM ≤ 2^WID_D.
- `ORDER_LAST`, 2^CNT_W−1: the order value that marks the final Horner term.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_vld` in 1: input beat valid.
- `in_rdy` out 1: block accepts a beat this cycle.
- `a_left` in WID_D: accumulated term.
- `a_right` in WID_D: multiplicand.
- `factor` in WID_F: evaluation point.
- `mode` in 1: 0 = add, 1 = subtract.
- `order_cnt` in CNT_W: order of the incoming term.
- `out_vld` out 1: result valid.
- `out_rdy` in 1: downstream accepts.
- `alu_o` out WID_D: result, always in the range 0..MOD_NUM−1.
- `order_cnt_o` out CNT_W: order_cnt+1, truncated to CNT_W bits.
- `wrap_o` out 1: set when order_cnt+1 overflowed CNT_W.
- `last_o` out 1: set when order_cnt_o == ORDER_LAST.

## Operation
- A beat transfers when in_vld && in_rdy. An output beat retires when out_vld && out_rdy.
- Stage S1, on accept:
  - p = (a_right·factor) mod MOD_NUM, full WID_D+WID_F product before reduction.
  - l = a_left mod MOD_NUM.
  - Register p, l, mode, and order_cnt+1 (CNT_W+1 bits).
- Stage S2:
  - Add: r = (l + p) mod MOD_NUM. Compute the sum at WID_D+1 bits and reduce by one conditional subtract.
  - Subtract: r = (l ≥ p) ? l−p : l+MOD_NUM−p.
  - Register r to alu_o.
  - wrap_o = bit CNT_W of the incremented count.
  - order_cnt_o = its low CNT_W bits.
  - last_o = (order_cnt_o == ORDER_LAST).
- Pipeline control is a global stall: advance = !out_vld || out_rdy.
  - in_rdy = advance. This is a combinational path from out_rdy, which is accepted.
  - S1 and S2 valid bits move only when advance=1.
  - Payload registers load only when their stage valid-in is 1 and advance=1.
- While out_vld=1 && out_rdy=0, all S2 outputs hold stable.
- Reset, asynchronous on rst=1: S1/S2 valids, alu_o, order_cnt_o, wrap_o, and last_o all go to 0, and in_rdy reads 1.
  - Reset mid-operation drops in-flight beats silently. There is no flush handshake.
- No state machine beyond the two valid bits. Occupancy is 0, 1, or 2 beats.

## Timing
- Latency is 2 cycles from accept to out_vld with no stall: a beat accepted at edge N appears at edge N+2.
- Throughput is 1 beat per cycle when out_rdy is held at 1.
- Stall: when out_rdy=0 with both stages full, in_rdy=0 in the same cycle. No beat is lost or duplicated.
- On resume, the held beat retires on the first out_rdy=1 edge, and S1 advances on that same edge.
- An accept and a retire in the same cycle are legal and keep occupancy unchanged.
- Outputs are registered. Only in_rdy is combinational.

## Structure
- Package `polyeval_pkg` holds:
  - the `mode` encoding constants (MODE_ADD=0, MODE_SUB=1);
  - a function `mod_add_sub(l, p, mode, m)` shared with future evaluator blocks.
- One natural sub-module, `polyeval_modmul`: the combinational product plus mod reduction for S1. It is isolated so a Barrett or multi-cycle implementation can replace it later.
- Top-level target is about 150–250 lines.

## Test plan
All scenarios use defaults (MOD_NUM=30, CNT_W=5).
- Add basic: a_left=5, a_right=7, factor=4, mode=0, order_cnt=2, out_rdy=1 → 2 cycles later alu_o=3, order_cnt_o=3, wrap_o=0, last_o=0.
- Subtract with borrow: a_left=5, a_right=7, factor=4, mode=1 → alu_o=7. Operand reduction: a_left=65, a_right=0 → alu_o=5.
- Wrap/last: order_cnt=30 → order_cnt_o=31, last_o=1. order_cnt=31 → order_cnt_o=0, wrap_o=1, last_o=0.
- Backpressure: stream 4 beats with out_rdy=0 for cycles 3–5 → in_rdy=0 while full, alu_o stable while stalled, all 4 results in order, none lost or duplicated.
- Back-to-back: 16 beats with random operands and out_rdy=1 → one result per cycle matching the reference model, latency 2.
- Reset mid-stream: assert rst with 2 beats in flight → out_vld=0 and all outputs 0 immediately. After release, a new beat produces the correct result with latency 2.

Source files
------------

// File: rtl/polyeval_pkg.sv
// Shared definitions for the polynomial evaluator datapath.
// Holds the add/subtract mode encoding and the modular add/subtract helper
// that the evaluator blocks use on already-reduced operands.
package polyeval_pkg;

  localparam int unsigned MAX_W = 64;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // (l +/- p) mod m for l, p already in 0..m-1; one conditional correction only.
  function automatic logic [MAX_W-1:0] mod_add_sub(
    input logic [MAX_W-1:0] l,
    input logic [MAX_W-1:0] p,
    input logic             mode,
    input logic [MAX_W-1:0] m
  );
    logic [MAX_W:0]   sum;
    logic [MAX_W-1:0] r;
    sum = {1'b0, l} + {1'b0, p};
    r   = '0;
    if (mode == MODE_SUB) begin
      // l + m - p cannot exceed m here, so modular wraparound of the
      // intermediate still lands on the true value.
      if (l >= p) r = l - p;
      else        r = l + m - p;
    end else begin
      if (sum >= {1'b0, m}) r = MAX_W'(sum - {1'b0, m});
      else                  r = MAX_W'(sum);
    end
    return r;
  endfunction

endpackage

// File: rtl/polyeval_modmul.sv
// Combinational S1 datapath: full-width product reduced mod MOD_NUM, plus
// reduction of the accumulated term. Kept separate so a Barrett or
// multi-cycle reducer can drop in later.
// Ports:
//   a_left  - accumulated term (reduced to l_c)
//   a_right - multiplicand
//   factor  - evaluation point
//   p_c     - (a_right*factor) mod MOD_NUM
//   l_c     - a_left mod MOD_NUM
module polyeval_modmul
  import polyeval_pkg::*;
#(
  parameter int unsigned      WID_D   = 32,
  parameter int unsigned      WID_F   = 32,
  parameter longint unsigned  MOD_NUM = 30
) (
  input  logic [WID_D-1:0] a_left,
  input  logic [WID_D-1:0] a_right,
  input  logic [WID_F-1:0] factor,
  output logic [WID_D-1:0] p_c,
  output logic [WID_D-1:0] l_c
);

  localparam int unsigned PW = WID_D + WID_F;
  // One extra bit so MOD_NUM == 2^WID_D stays representable.
  localparam logic [PW-1:0]  MOD_P = PW'(MOD_NUM);
  localparam logic [WID_D:0] MOD_L = (WID_D+1)'(MOD_NUM);

  logic [PW-1:0] prod_c;

  assign prod_c = PW'(a_right) * PW'(factor);
  assign p_c    = WID_D'(prod_c % MOD_P);
  assign l_c    = WID_D'({1'b0, a_left} % MOD_L);

endmodule

// File: rtl/polyeval_mac_pipe.sv
// Two-stage pipelined modular multiply-accumulate step:
//   alu_o = (a_left +/- a_right*factor) mod MOD_NUM
// with the incremented order count, its wrap flag and a last-term flag
// travelling alongside. A single global stall drives both stages.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_vld / in_rdy   - input handshake (in_rdy is combinational from out_rdy)
//   a_left, a_right, factor, mode, order_cnt - input beat payload
//   out_vld / out_rdy - output handshake
//   alu_o, order_cnt_o, wrap_o, last_o       - registered result payload
module polyeval_mac_pipe
  import polyeval_pkg::*;
#(
  parameter int unsigned     WID_D      = 32,
  parameter int unsigned     WID_F      = 32,
  parameter int unsigned     CNT_W      = 5,
  parameter longint unsigned MOD_NUM    = 30,
  parameter int unsigned     ORDER_LAST = (1 << CNT_W) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WID_D-1:0] a_left,
  input  logic [WID_D-1:0] a_right,
  input  logic [WID_F-1:0] factor,
  input  logic             mode,
  input  logic [CNT_W-1:0] order_cnt,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WID_D-1:0] alu_o,
  output logic [CNT_W-1:0] order_cnt_o,
  output logic             wrap_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ORDER_LAST);

  logic [WID_D-1:0] p_c;
  logic [WID_D-1:0] l_c;
  logic [WID_D-1:0] r_c;

  logic             s1_vld;
  logic [WID_D-1:0] s1_p;
  logic [WID_D-1:0] s1_l;
  logic             s1_mode;
  logic [CNT_W:0]   s1_cnt;

  // Global stall: everything moves together when the output slot frees up.
  assign in_rdy = !out_vld || out_rdy;

  polyeval_modmul #(
    .WID_D   (WID_D),
    .WID_F   (WID_F),
    .MOD_NUM (MOD_NUM)
  ) u_modmul (
    .a_left  (a_left),
    .a_right (a_right),
    .factor  (factor),
    .p_c     (p_c),
    .l_c     (l_c)
  );

  // S2 combine of the registered, already-reduced operands.
  always_comb begin
    r_c = '0;
    r_c = WID_D'(mod_add_sub(MAX_W'(s1_l), MAX_W'(s1_p), s1_mode, MAX_W'(MOD_NUM)));
  end

  // Pipeline registers; payloads load only with a valid beat behind them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      s1_p        <= '0;
      s1_l        <= '0;
      s1_mode     <= MODE_ADD;
      s1_cnt      <= '0;
      out_vld     <= 1'b0;
      alu_o       <= '0;
      order_cnt_o <= '0;
      wrap_o      <= 1'b0;
      last_o      <= 1'b0;
    end else if (in_rdy) begin
      s1_vld  <= in_vld;
      out_vld <= s1_vld;
      if (in_vld) begin
        s1_p    <= p_c;
        s1_l    <= l_c;
        s1_mode <= mode;
        s1_cnt  <= {1'b0, order_cnt} + (CNT_W+1)'(1);
      end
      if (s1_vld) begin
        alu_o       <= r_c;
        order_cnt_o <= s1_cnt[CNT_W-1:0];
        wrap_o      <= s1_cnt[CNT_W];
        last_o      <= (s1_cnt[CNT_W-1:0] == LAST_CNT);
      end
    end
  end

endmodule

// File: tb/tb_polyeval_mac_pipe.sv
// Self-checking bench for polyeval_mac_pipe at default parameters
// (MOD_NUM=30, CNT_W=5). Expected results come from a plain-arithmetic
// model queued at each accepted beat.
module tb_polyeval_mac_pipe;

  localparam int unsigned WD   = 32;
  localparam int unsigned WF   = 32;
  localparam int unsigned CW   = 5;
  localparam longint unsigned MODV = 30;

  typedef struct {
    logic [WD-1:0] r;
    logic [CW-1:0] c;
    logic          w;
    logic          l;
    int            acc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [WD-1:0] a_left;
  logic [WD-1:0] a_right;
  logic [WF-1:0] factor;
  logic          mode;
  logic [CW-1:0] order_cnt;
  logic          out_vld;
  logic          out_rdy;
  logic [WD-1:0] alu_o;
  logic [CW-1:0] order_cnt_o;
  logic          wrap_o;
  logic          last_o;

  int   checks;
  int   errors;
  int   stp;
  int   retired;
  bit   lat_chk;
  bit   acc_now;
  bit   stall_seen;
  exp_t q[$];

  polyeval_mac_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .a_left      (a_left),
    .a_right     (a_right),
    .factor      (factor),
    .mode        (mode),
    .order_cnt   (order_cnt),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .alu_o       (alu_o),
    .order_cnt_o (order_cnt_o),
    .wrap_o      (wrap_o),
    .last_o      (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WD-1:0] al, input logic [WD-1:0] ar,
                                 input logic [WF-1:0] f, input logic md,
                                 input logic [CW-1:0] oc, input int at);
    exp_t e;
    longint unsigned prod, pm, lm, r;
    int unsigned cnt;
    prod = 64'(ar) * 64'(f);
    pm   = prod % MODV;
    lm   = 64'(al) % MODV;
    r    = md ? (lm + MODV - pm) % MODV : (lm + pm) % MODV;
    cnt  = 32'(oc) + 1;
    e.r   = WD'(r);
    e.c   = CW'(cnt % 32);
    e.w   = (cnt >= 32);
    e.l   = ((cnt % 32) == 31);
    e.acc = at;
    return e;
  endfunction

  // One clock: sample mid-cycle, score retire/accept, advance to next negedge.
  task automatic step();
    exp_t e;
    #1;
    chk("in_rdy", 64'(in_rdy), 64'(!out_vld || out_rdy));
    if (out_vld && !out_rdy) stall_seen = 1'b1;
    if (out_vld) begin
      chk("out_has_beat", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q[0];
        chk("alu_o", 64'(alu_o), 64'(e.r));
        chk("order_cnt_o", 64'(order_cnt_o), 64'(e.c));
        chk("wrap_o", 64'(wrap_o), 64'(e.w));
        chk("last_o", 64'(last_o), 64'(e.l));
        if (lat_chk && out_rdy) chk("latency", 64'(stp - e.acc), 64'd2);
        if (out_rdy) begin
          void'(q.pop_front());
          retired++;
        end
      end
    end
    acc_now = in_vld && in_rdy;
    if (acc_now) q.push_back(model(a_left, a_right, factor, mode, order_cnt, stp));
    stp++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [WD-1:0] al, input logic [WD-1:0] ar,
                       input logic [WF-1:0] f, input logic md, input logic [CW-1:0] oc);
    a_left = al; a_right = ar; factor = f; mode = md; order_cnt = oc;
  endtask

  task automatic drive_rand();
    drive(WD'($urandom()), WD'($urandom()), WF'($urandom()), 1'($urandom()), CW'($urandom()));
  endtask

  // Single beat into an empty pipe; result checked against fixed values two edges later.
  task automatic directed(input logic [WD-1:0] al, input logic [WD-1:0] ar,
                          input logic [WF-1:0] f, input logic md, input logic [CW-1:0] oc,
                          input int er, input int ec, input bit ew, input bit el, input string tag);
    drive(al, ar, f, md, oc);
    in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    #1;
    chk({tag, "_not_early"}, 64'(out_vld), 64'd0);
    step();
    #1;
    chk({tag, "_vld"}, 64'(out_vld), 64'd1);
    chk({tag, "_alu"}, 64'(alu_o), 64'(er));
    chk({tag, "_cnt"}, 64'(order_cnt_o), 64'(ec));
    chk({tag, "_wrap"}, 64'(wrap_o), 64'(ew));
    chk({tag, "_last"}, 64'(last_o), 64'(el));
    step();
  endtask

  initial begin
    int sent;
    int r0;
    checks = 0; errors = 0; stp = 0; retired = 0;
    lat_chk = 1'b0; stall_seen = 1'b0; acc_now = 1'b0;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
    drive('0, '0, '0, 1'b0, '0);

    // Reset state
    #2;
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_alu", 64'(alu_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic and count boundaries
    lat_chk = 1'b1;
    directed(32'd5,  32'd7, 32'd4, 1'b0, 5'd2,  3, 3,  1'b0, 1'b0, "add_basic");
    directed(32'd5,  32'd7, 32'd4, 1'b1, 5'd2,  7, 3,  1'b0, 1'b0, "sub_borrow");
    directed(32'd65, 32'd0, 32'd9, 1'b0, 5'd0,  5, 1,  1'b0, 1'b0, "reduce_left");
    directed(32'd1,  32'd1, 32'd1, 1'b0, 5'd30, 2, 31, 1'b0, 1'b1, "last");
    directed(32'd1,  32'd1, 32'd1, 1'b0, 5'd31, 2, 0,  1'b1, 1'b0, "wrap");
    directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd7, 0, 8, 1'b0, 1'b0, "max_ops");

    // Back-to-back: 16 random beats, one result per cycle at latency 2
    r0 = retired;
    in_vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_rand();
      step();
      chk("b2b_accept", 64'(acc_now), 64'd1);
    end
    in_vld = 1'b0;
    step();
    step();
    chk("b2b_retired", 64'(retired - r0), 64'd16);
    chk("b2b_drained", 64'(q.size()), 64'd0);

    // Backpressure: 4 beats, out_rdy low on cycles 3..5
    lat_chk = 1'b0;
    r0 = retired;
    sent = 0;
    drive_rand();
    for (int i = 0; i < 20; i++) begin
      in_vld  = (sent < 4);
      out_rdy = !(i >= 3 && i <= 5);
      step();
      if (acc_now) begin
        sent++;
        drive_rand();
      end
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    chk("bp_stall_seen", 64'(stall_seen), 64'd1);
    chk("bp_sent", 64'(sent), 64'd4);
    chk("bp_retired", 64'(retired - r0), 64'd4);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Reset with two beats in flight
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    drive_rand();
    step();
    drive_rand();
    step();
    in_vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_alu", 64'(alu_o), 64'd0);
    chk("mid_rst_cnt", 64'(order_cnt_o), 64'd0);
    chk("mid_rst_wrap", 64'(wrap_o), 64'd0);
    chk("mid_rst_last", 64'(last_o), 64'd0);
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    lat_chk = 1'b1;
    r0 = retired;
    directed(32'd29, 32'd3, 32'd10, 1'b0, 5'd31, 29, 0, 1'b1, 1'b0, "post_rst");
    step();
    chk("post_rst_retired", 64'(retired - r0), 64'd1);
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
